alu_arbiter: RTL and testbench

Shares the single registered `alu` between two requesters, for example the execute stage and a secondary issue port, using a round-robin valid/ready handshake. The arbiter grants one requester and drives registered operands and `aluOp` into the ALU. It waits out the ALU's clocked latency, captures `result`/`zero`, and returns them on the granted requester's response channel, holding them until that requester accepts. It sits between the requesters and `alu`, and it is the only block that drives the ALU's operand inputs.

---
 rtl/alu_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; response ALU_LATENCY+2 cycles after grant.
// A response is held until its requester accepts it, and no new request is granted until then.
module alu_arbiter #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [6:0]  req0_aluOp,
  input  logic [6:0]  req1_aluOp,
  output logic        resp0_valid,
  output logic        resp1_valid,
  input  logic        resp0_ready,
  input  logic        resp1_ready,
  output logic [31:0] resp0_result,
  output logic [31:0] resp1_result,
  output logic        resp0_zero,
  output logic        resp1_zero,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [6:0]  alu_aluOp,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        busy
);

  localparam int CW = $clog2(ALU_LATENCY + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(ALU_LATENCY);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          last_grant;
  logic          sel0, sel1;
  logic          capture;
  logic          release_resp;

  // On a tie the requester that was not granted last time wins.
  assign sel0 = req0_valid & (~req1_valid | last_grant);
  assign sel1 = req1_valid & (~req0_valid | ~last_grant);
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    capture      = 1'b0;
    release_resp = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = sel0 & ~reset;
        req1_ready = sel1 & ~reset;
        if (sel0 | sel1) state_nxt = EXEC;
      end
      EXEC: begin
        if (cnt == CNT_DONE) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (owner ? resp1_ready : resp0_ready) begin
          release_resp = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      alu_op1      <= '0;
      alu_op2      <= '0;
      alu_aluOp    <= '0;
      resp0_valid  <= 1'b0;
      resp1_valid  <= 1'b0;
      resp0_result <= '0;
      resp1_result <= '0;
      resp0_zero   <= 1'b0;
      resp1_zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req0_ready | req1_ready) begin
        alu_op1    <= req1_ready ? req1_op1   : req0_op1;
        alu_op2    <= req1_ready ? req1_op2   : req0_op2;
        alu_aluOp  <= req1_ready ? req1_aluOp : req0_aluOp;
        owner      <= req1_ready;
        last_grant <= req1_ready;
        cnt        <= '0;
      end else if (state == EXEC && !capture) begin
        cnt <= cnt + CW'(1);
      end
      if (capture) begin
        if (owner) begin
          resp1_result <= alu_result;
          resp1_zero   <= alu_zero;
          resp1_valid  <= 1'b1;
        end else begin
          resp0_result <= alu_result;
          resp0_zero   <= alu_zero;
          resp0_valid  <= 1'b1;
        end
      end
      if (release_resp) begin
        if (owner) resp1_valid <= 1'b0;
        else       resp0_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: two arbiters (latency 1 and 3) each driving a stub ALU.
module tb_alu_arbiter;
  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_SUB = 7'h20;
  localparam logic [6:0] OP_MUL = 7'h01;

  logic clock = 1'b0;
  logic reset;
  int tests = 0;
  int failed = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [6:0] op);
    case (op)
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a - b;
      OP_MUL:  alu_f = a * b;
      default: alu_f = 32'h0;
    endcase
  endfunction

  // Latency-1 instance
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [6:0]  req0_aluOp, req1_aluOp;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp0_result, resp1_result;
  logic        resp0_zero, resp1_zero;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [6:0]  alu_aluOp;
  logic        alu_zero, busy;

  always @(posedge clock) alu_result <= alu_f(alu_op1, alu_op2, alu_aluOp);
  assign alu_zero = (alu_result == 32'h0);

  alu_arbiter #(.ALU_LATENCY(1)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req0_aluOp(req0_aluOp), .req1_aluOp(req1_aluOp),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
    .resp0_result(resp0_result), .resp1_result(resp1_result),
    .resp0_zero(resp0_zero), .resp1_zero(resp1_zero),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_aluOp(alu_aluOp),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // Latency-3 instance
  logic        l_req0_valid, l_req1_valid, l_req0_ready, l_req1_ready;
  logic [31:0] l_req0_op1, l_req0_op2, l_req1_op1, l_req1_op2;
  logic [6:0]  l_req0_aluOp, l_req1_aluOp;
  logic        l_resp0_valid, l_resp1_valid, l_resp0_ready, l_resp1_ready;
  logic [31:0] l_resp0_result, l_resp1_result;
  logic        l_resp0_zero, l_resp1_zero;
  logic [31:0] l_alu_op1, l_alu_op2;
  logic [6:0]  l_alu_aluOp;
  logic        l_busy;
  logic [31:0] l_pipe [3];

  always @(posedge clock) begin
    l_pipe[0] <= alu_f(l_alu_op1, l_alu_op2, l_alu_aluOp);
    l_pipe[1] <= l_pipe[0];
    l_pipe[2] <= l_pipe[1];
  end

  alu_arbiter #(.ALU_LATENCY(3)) dut_l3 (
    .clock(clock), .reset(reset),
    .req0_valid(l_req0_valid), .req1_valid(l_req1_valid),
    .req0_ready(l_req0_ready), .req1_ready(l_req1_ready),
    .req0_op1(l_req0_op1), .req0_op2(l_req0_op2), .req1_op1(l_req1_op1), .req1_op2(l_req1_op2),
    .req0_aluOp(l_req0_aluOp), .req1_aluOp(l_req1_aluOp),
    .resp0_valid(l_resp0_valid), .resp1_valid(l_resp1_valid),
    .resp0_ready(l_resp0_ready), .resp1_ready(l_resp1_ready),
    .resp0_result(l_resp0_result), .resp1_result(l_resp1_result),
    .resp0_zero(l_resp0_zero), .resp1_zero(l_resp1_zero),
    .alu_op1(l_alu_op1), .alu_op2(l_alu_op2), .alu_aluOp(l_alu_aluOp),
    .alu_result(l_pipe[2]), .alu_zero(l_pipe[2] == 32'h0), .busy(l_busy)
  );

  // Advance into the next cycle; inputs are driven just after the edge, outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    req0_op1 = 0; req0_op2 = 0; req1_op1 = 0; req1_op2 = 0; req0_aluOp = 0; req1_aluOp = 0;
    l_req0_valid = 0; l_req1_valid = 0; l_resp0_ready = 0; l_resp1_ready = 0;
    l_req0_op1 = 0; l_req0_op2 = 0; l_req1_op1 = 0; l_req1_op2 = 0; l_req0_aluOp = 0; l_req1_aluOp = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    repeat (2) tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    req0_valid = 1; req1_valid = 1; req0_op1 = 32'h55; resp0_ready = 1;
    tick(); tick();
    @(negedge clock);
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failed++;
      $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready); end
    tests++; if (busy !== 1'b0 || l_busy !== 1'b0) begin failed++;
      $display("FAIL reset_busy got %b/%b exp 0/0", busy, l_busy); end
    tests++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin failed++;
      $display("FAIL reset_resp_valid got %b%b exp 00", resp0_valid, resp1_valid); end
    tests++; if (alu_op1 !== 32'h0 || alu_op2 !== 32'h0 || alu_aluOp !== 7'h0) begin failed++;
      $display("FAIL reset_alu_regs got %h %h %h exp 0", alu_op1, alu_op2, alu_aluOp); end
    tests++; if (resp0_result !== 32'h0 || resp1_result !== 32'h0 || resp0_zero !== 1'b0 || resp1_zero !== 1'b0) begin failed++;
      $display("FAIL reset_resp_data got %h %h %b %b exp 0", resp0_result, resp1_result, resp0_zero, resp1_zero); end
    reset = 0;
    clear_inputs();
    tick();
    @(negedge clock);
    tests++; if (busy !== 1'b0) begin failed++;
      $display("FAIL reset_accept_blocked got busy=%b exp 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1; req0_op1 = 5; req0_op2 = 7; req0_aluOp = OP_ADD; resp0_ready = 1;
    @(negedge clock);
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failed++;
      $display("FAIL single_grant got %b%b exp 10", req0_ready, req1_ready); end
    tick(); req0_valid = 0;
    @(negedge clock);
    tests++; if (busy !== 1'b1 || alu_op1 !== 32'd5 || alu_op2 !== 32'd7) begin failed++;
      $display("FAIL single_c1 got busy=%b op1=%0d op2=%0d exp 1 5 7", busy, alu_op1, alu_op2); end
    tick();
    @(negedge clock);
    tests++; if (busy !== 1'b1 || resp0_valid !== 1'b0) begin failed++;
      $display("FAIL single_c2 got busy=%b valid=%b exp 1 0", busy, resp0_valid); end
    tick();
    @(negedge clock);
    tests++; if (resp0_valid !== 1'b1 || resp0_result !== 32'd12 || resp0_zero !== 1'b0 || busy !== 1'b1) begin failed++;
      $display("FAIL single_c3 got v=%b r=%0d z=%b busy=%b exp 1 12 0 1", resp0_valid, resp0_result, resp0_zero, busy); end
    tick();
    @(negedge clock);
    tests++; if (busy !== 1'b0 || resp0_valid !== 1'b0) begin failed++;
      $display("FAIL single_c4 got busy=%b v=%b exp 0 0", busy, resp0_valid); end
  endtask

  task automatic test_tie();
    do_reset();
    req0_valid = 1; req0_op1 = 10; req0_op2 = 10; req0_aluOp = OP_SUB;
    req1_valid = 1; req1_op1 = 6;  req1_op2 = 7;  req1_aluOp = OP_MUL;
    resp0_ready = 1; resp1_ready = 1;
    @(negedge clock);
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failed++;
      $display("FAIL tie_first got %b%b exp 10", req0_ready, req1_ready); end
    tick(); req0_valid = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      tests++; if (resp1_valid !== 1'b0 || req1_ready !== 1'b0) begin failed++;
        $display("FAIL tie_wait_c%0d got v1=%b rdy1=%b exp 0 0", c, resp1_valid, req1_ready); end
      if (c < 3) tick();
    end
    tests++; if (resp0_valid !== 1'b1 || resp0_result !== 32'd0 || resp0_zero !== 1'b1) begin failed++;
      $display("FAIL tie_resp0 got v=%b r=%0d z=%b exp 1 0 1", resp0_valid, resp0_result, resp0_zero); end
    tick();
    @(negedge clock);
    tests++; if (req1_ready !== 1'b1) begin failed++;
      $display("FAIL tie_second got rdy1=%b exp 1", req1_ready); end
    tick(); req1_valid = 0;
    tick(); tick();
    @(negedge clock);
    tests++; if (resp1_valid !== 1'b1 || resp1_result !== 32'd42 || resp1_zero !== 1'b0) begin failed++;
      $display("FAIL tie_resp1 got v=%b r=%0d z=%b exp 1 42 0", resp1_valid, resp1_result, resp1_zero); end
  endtask

  task automatic test_round_robin();
    int grants;
    logic order [8];
    do_reset();
    grants = 0;
    req0_valid = 1; req0_op1 = 1; req0_op2 = 1; req0_aluOp = OP_ADD;
    req1_valid = 1; req1_op1 = 2; req1_op2 = 2; req1_aluOp = OP_ADD;
    resp0_ready = 1; resp1_ready = 1;
    for (int c = 0; c < 60 && grants < 8; c++) begin
      @(negedge clock);
      tests++; if (req0_ready && req1_ready) begin failed++;
        $display("FAIL rr_both_ready cycle %0d got 11 exp at most one", c); end
      if (req0_ready) begin order[grants] = 1'b0; grants++; end
      else if (req1_ready) begin order[grants] = 1'b1; grants++; end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    tests++; if (grants != 8) begin failed++;
      $display("FAIL rr_grant_count got %0d exp 8", grants); end
    for (int i = 0; i < grants; i++) begin
      tests++; if (order[i] !== i[0]) begin failed++;
        $display("FAIL rr_order[%0d] got %b exp %b", i, order[i], i[0]); end
    end
    tick(); tick(); tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid = 1; req0_op1 = 2; req0_op2 = 3; req0_aluOp = OP_ADD; resp0_ready = 0;
    tick(); req0_valid = 0;
    req1_valid = 1; req1_op1 = 8; req1_op2 = 9; req1_aluOp = OP_ADD; resp1_ready = 1;
    tick(); tick();
    for (int c = 3; c <= 7; c++) begin
      @(negedge clock);
      tests++; if (resp0_valid !== 1'b1 || resp0_result !== 32'd5 || resp0_zero !== 1'b0 || req1_ready !== 1'b0) begin failed++;
        $display("FAIL bp_hold_c%0d got v=%b r=%0d z=%b rdy1=%b exp 1 5 0 0", c, resp0_valid, resp0_result, resp0_zero, req1_ready); end
      tick();
    end
    resp0_ready = 1;
    resp1_ready = 1;
    @(negedge clock);
    tests++; if (resp0_valid !== 1'b1 || req1_ready !== 1'b0) begin failed++;
      $display("FAIL bp_release got v=%b rdy1=%b exp 1 0", resp0_valid, req1_ready); end
    tick();
    @(negedge clock);
    tests++; if (busy !== 1'b0 || resp0_valid !== 1'b0 || req1_ready !== 1'b1) begin failed++;
      $display("FAIL bp_idle got busy=%b v0=%b rdy1=%b exp 0 0 1", busy, resp0_valid, req1_ready); end
    tick(); req1_valid = 0;
    tick(); tick();
    @(negedge clock);
    tests++; if (resp1_valid !== 1'b1 || resp1_result !== 32'd17) begin failed++;
      $display("FAIL bp_resp1 got v=%b r=%0d exp 1 17", resp1_valid, resp1_result); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req0_valid = 1; req0_op1 = 3; req0_op2 = 4; req0_aluOp = OP_ADD; resp0_ready = 1;
    tick(); req0_valid = 0; reset = 1;
    tick(); reset = 0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clock);
      tests++; if (resp0_valid !== 1'b0 || busy !== 1'b0) begin failed++;
        $display("FAIL mid_reset_c%0d got v=%b busy=%b exp 0 0", c, resp0_valid, busy); end
      if (c == 2) begin
        tests++; if (alu_op1 !== 32'h0 || alu_op2 !== 32'h0 || resp0_result !== 32'h0) begin failed++;
          $display("FAIL mid_reset_regs got %h %h %h exp 0", alu_op1, alu_op2, resp0_result); end
      end
      tick();
    end
    req0_valid = 1; req0_op1 = 1; req0_op2 = 2; req0_aluOp = OP_ADD;
    @(negedge clock);
    tests++; if (req0_ready !== 1'b1) begin failed++;
      $display("FAIL mid_reset_regrant got %b exp 1", req0_ready); end
    tick(); req0_valid = 0;
    tick(); tick();
    @(negedge clock);
    tests++; if (resp0_valid !== 1'b1 || resp0_result !== 32'd3) begin failed++;
      $display("FAIL mid_reset_fresh got v=%b r=%0d exp 1 3", resp0_valid, resp0_result); end
  endtask

  task automatic test_long_latency();
    do_reset();
    l_req0_valid = 1; l_req0_op1 = 32'd100; l_req0_op2 = 32'hFFFF_FFFF; l_req0_aluOp = OP_ADD; l_resp0_ready = 1;
    @(negedge clock);
    tests++; if (l_req0_ready !== 1'b1) begin failed++;
      $display("FAIL l3_grant got %b exp 1", l_req0_ready); end
    tick(); l_req0_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      tests++; if (l_alu_op1 !== 32'd100 || l_alu_op2 !== 32'hFFFF_FFFF || l_resp0_valid !== 1'b0 || l_busy !== 1'b1) begin failed++;
        $display("FAIL l3_exec_c%0d got op1=%h op2=%h v=%b busy=%b exp 64 ffffffff 0 1", c, l_alu_op1, l_alu_op2, l_resp0_valid, l_busy); end
      tick();
    end
    @(negedge clock);
    tests++; if (l_resp0_valid !== 1'b1 || l_resp0_result !== 32'd99 || l_resp0_zero !== 1'b0) begin failed++;
      $display("FAIL l3_resp got v=%b r=%0d z=%b exp 1 99 0", l_resp0_valid, l_resp0_result, l_resp0_zero); end
    tick();
    @(negedge clock);
    tests++; if (l_resp0_valid !== 1'b0 || l_busy !== 1'b0) begin failed++;
      $display("FAIL l3_done got v=%b busy=%b exp 0 0", l_resp0_valid, l_busy); end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_single();
    test_tie();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_long_latency();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
